sound_sequencer: RTL and testbench

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

---
 rtl/sound_pkg.sv | 31 +++
 rtl/sound_evt_fifo.sv | 32 +++
 rtl/sound_sequencer.sv | 72 +++++++
 tb/tb_sound_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: event and note codes, FSM states and melody ROM for the sound sequencer
package sound_pkg;
    localparam logic [2:0] EV_SELECT = 3'd1;
    localparam logic [2:0] EV_MOVE   = 3'd2;
    localparam logic [2:0] EV_CHECK  = 3'd3;
    localparam logic [2:0] EV_WIN    = 3'd4;
    localparam logic [2:0] EV_LOSE   = 3'd5;
    localparam logic [2:0] NT_1 = 3'd1;
    localparam logic [2:0] NT_2 = 3'd2;
    localparam logic [2:0] NT_3 = 3'd3;
    localparam logic [2:0] NT_4 = 3'd4;
    localparam logic [2:0] NT_5 = 3'd5;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
    localparam logic [1:0] MEL_LAST [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    function automatic logic [2:0] melody_note(input logic [4:0] a);
        case (a)
            {EV_SELECT, 2'd0}: return NT_1;
            {EV_MOVE, 2'd0}:   return NT_2;
            {EV_CHECK, 2'd0}:  return NT_3;
            {EV_CHECK, 2'd1}:  return NT_3;
            {EV_WIN, 2'd0}:    return NT_3;
            {EV_WIN, 2'd1}:    return NT_2;
            {EV_WIN, 2'd2}:    return NT_1;
            {EV_WIN, 2'd3}:    return NT_4;
            {EV_LOSE, 2'd0}:   return NT_2;
            {EV_LOSE, 2'd1}:   return NT_3;
            {EV_LOSE, 2'd2}:   return NT_5;
            default:           return 3'd0;
        endcase
    endfunction
endpackage

// File: rtl/sound_evt_fifo.sv
// sound_evt_fifo: small power-of-two event queue with synchronous flush
module sound_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= flush ? '0 : push ? wp + (AW+1)'(1) : wp;
            rp <= flush ? '0 : pop ? rp + (AW+1)'(1) : rp;
        end
    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= din;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: queues game events and plays each event's melody as timed note strobes
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int NOTE_GAP   = 12_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ev_valid,
    input  logic [2:0] ev_type,
    input  logic       clear,
    input  logic       mute,
    output logic [2:0] sound_code,
    output logic       play_sound,
    output logic       busy,
    output logic [7:0] drop_cnt
);
    localparam int CW = $clog2(NOTE_GAP);
    state_t        state, state_n;
    logic [2:0]    ev_reg, dout;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic          full, empty, legal, push, pop, drop, last;
    assign legal = ev_valid && ev_type != 3'd0 && ev_type <= EV_LOSE;
    assign push  = legal && !full && !clear;
    assign drop  = legal && full && !clear;
    assign pop   = state == S_IDLE && !empty && !clear;
    assign last  = idx == MEL_LAST[ev_reg];
    assign busy  = state != S_IDLE || !empty;
    sound_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(3)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (clear),
        .din   (ev_type),
        .full  (full),
        .empty (empty),
        .dout  (dout)
    );
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= S_IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: state_n = empty ? S_IDLE : S_LOAD;
            S_LOAD: state_n = S_PLAY;
            S_PLAY: state_n = S_GAP;
            S_GAP:  state_n = cnt != '0 ? S_GAP : last ? S_IDLE : S_PLAY;
        endcase
        if (clear) state_n = S_IDLE;
    end
    // outputs are registered on the PLAY edge, so the strobe lands one cycle after PLAY is entered
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            ev_reg     <= '0;
            idx        <= '0;
            cnt        <= '0;
            sound_code <= '0;
            play_sound <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            ev_reg     <= pop ? dout : ev_reg;
            idx        <= state == S_LOAD ? 2'd0 : (state == S_GAP && cnt == '0 && !last) ? idx + 2'd1 : idx;
            cnt        <= state == S_PLAY ? CW'(NOTE_GAP - 1) : (state == S_GAP && cnt != '0) ? cnt - CW'(1) : cnt;
            sound_code <= (state == S_PLAY && !clear) ? melody_note({ev_reg, idx}) : sound_code;
            play_sound <= state == S_PLAY && !mute && !clear;
            drop_cnt   <= (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
        end
endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed scenario table, reset and saturation sequences, and random traffic against a timeline model
module tb_sound_sequencer;
    localparam int G = 4;
    localparam int D = 4;
    logic       clk = 1'b0, rstn = 1'b0, ev_valid = 1'b0, clear = 1'b0, mute = 1'b0;
    logic [2:0] ev_type = 3'd0;
    logic [2:0] sound_code;
    logic       play_sound, busy;
    logic [7:0] drop_cnt;
    sound_sequencer #(.NOTE_GAP(G), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ev_valid   (ev_valid),
        .ev_type    (ev_type),
        .clear      (clear),
        .mute       (mute),
        .sound_code (sound_code),
        .play_sound (play_sound),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    int cyc, busy_until, e_code, e_drop, e_play, n_pulse, last_pulse, last_busy;
    int q[$], pt[$], pc[$];
    int mel_len [8] = '{0, 1, 1, 2, 4, 3, 0, 0};
    int mel [8][4] = '{'{0,0,0,0}, '{1,0,0,0}, '{2,0,0,0}, '{3,3,0,0},
                       '{3,2,1,4}, '{2,3,5,0}, '{0,0,0,0}, '{0,0,0,0}};
    typedef struct {
        string      name;
        logic [2:0] typ;
        int         n_ev;
        logic       mt;
        int         clr_at;
        int         exp_pulses;
        int         exp_last;
        int         exp_drop;
        int         exp_code;
        int         quiet_from;
    } scen_t;
    scen_t sc [8];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask
    task automatic model_reset();
        cyc = 0; busy_until = 0; e_code = 0; e_drop = 0;
        n_pulse = 0; last_pulse = -1; last_busy = -1;
        q.delete(); pt.delete(); pc.delete();
    endtask
    task automatic do_reset();
        ev_valid = 1'b0; ev_type = 3'd0; clear = 1'b0; mute = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
    endtask
    // model: an event popped at edge e plays notes at e+2+k*(G+1); the block idles G cycles after its last note
    task automatic tick(input logic v, input logic [2:0] t, input logic c, input logic m);
        bit legal, pop_now;
        int cnt0, h;
        @(negedge clk);
        ev_valid = v; ev_type = t; clear = c; mute = m;
        @(posedge clk);
        cyc++;
        legal   = v && t >= 3'd1 && t <= 3'd5;
        cnt0    = q.size();
        pop_now = (cyc - 1 >= busy_until) && cnt0 > 0 && !c;
        e_play  = 0;
        if (c) begin
            q.delete(); pt.delete(); pc.delete();
            busy_until = cyc;
        end else begin
            if (pop_now) begin
                h = q.pop_front();
                for (int k = 0; k < mel_len[h]; k++) begin
                    pt.push_back(cyc + 2 + k * (G + 1));
                    pc.push_back(mel[h][k]);
                end
                busy_until = cyc + 2 + (mel_len[h] - 1) * (G + 1) + G;
            end
            if (legal) begin
                if (cnt0 < D) q.push_back(int'(t));
                else if (e_drop < 255) e_drop++;
            end
            if (pt.size() > 0 && pt[0] == cyc) begin
                e_code = pc.pop_front();
                void'(pt.pop_front());
                e_play = m ? 0 : 1;
            end
        end
        #1;
        chk("play_sound", int'(play_sound), e_play);
        chk("sound_code", int'(sound_code), e_code);
        chk("busy", int'(busy), (cyc < busy_until || q.size() > 0) ? 1 : 0);
        chk("drop_cnt", int'(drop_cnt), e_drop);
        if (play_sound) begin n_pulse++; last_pulse = cyc; end
        if (busy) last_busy = cyc;
    endtask
    initial begin
        logic mt;
        sc[0] = '{"move",      3'd2, 1, 1'b0, 0,  1, 13, 0, 2, 18};
        sc[1] = '{"win",       3'd4, 1, 1'b0, 0,  4, 28, 0, 4, 32};
        sc[2] = '{"move_x6",   3'd2, 6, 1'b0, 0,  5, 41, 1, 2, 45};
        sc[3] = '{"win_mute",  3'd4, 1, 1'b1, 0,  0, -1, 0, 4, 32};
        sc[4] = '{"win_clear", 3'd4, 1, 1'b0, 21, 2, 18, 0, 2, 21};
        sc[5] = '{"lose",      3'd5, 1, 1'b0, 0,  3, 23, 0, 5, 27};
        sc[6] = '{"check",     3'd3, 1, 1'b0, 0,  2, 18, 0, 3, 22};
        sc[7] = '{"illegal6",  3'd6, 6, 1'b0, 0,  0, -1, 0, 0, 1};
        model_reset();
        rstn = 1'b0;
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_play", int'(play_sound), 0);
        chk("reset_code", int'(sound_code), 0);
        chk("reset_drop", int'(drop_cnt), 0);
        foreach (sc[i]) begin
            do_reset();
            for (int k = 1; k <= 60; k++)
                tick(k >= 10 && k < 10 + sc[i].n_ev, sc[i].typ, k == sc[i].clr_at, sc[i].mt);
            chk({sc[i].name, "_pulses"}, n_pulse, sc[i].exp_pulses);
            chk({sc[i].name, "_last_pulse"}, last_pulse, sc[i].exp_last);
            chk({sc[i].name, "_drop"}, int'(drop_cnt), sc[i].exp_drop);
            chk({sc[i].name, "_code"}, int'(sound_code), sc[i].exp_code);
            chk({sc[i].name, "_quiet"}, (last_busy < sc[i].quiet_from) ? 1 : 0, 1);
        end
        do_reset();
        for (int k = 1; k <= 15; k++) tick(k == 10, 3'd4, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_play", int'(play_sound), 0);
        chk("async_rst_code", int'(sound_code), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_drop", int'(drop_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
        for (int k = 1; k <= 30; k++) tick(1'b0, 3'd0, 1'b0, 1'b0);
        chk("post_rst_pulses", n_pulse, 0);
        do_reset();
        for (int k = 1; k <= 400; k++) tick(1'b1, 3'd2, 1'b0, 1'b0);
        chk("drop_saturate", int'(drop_cnt), 255);
        do_reset();
        mt = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) mt = !mt;
            tick($urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 149) == 0, mt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
